// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: opcodes, condition codes, shift types,
// NZCV bit positions and small decode helpers.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_EOR = 4'b0010;
    localparam logic [3:0] OP_MVN = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SBC = 4'b0111;
    localparam logic [3:0] OP_RSB = 4'b1000;
    localparam logic [3:0] OP_MOV = 4'b1001;
    localparam logic [3:0] OP_TST = 4'b1010;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_CMN = 4'b1100;
    localparam logic [3:0] OP_TEQ = 4'b1101;

    localparam logic [3:0] CC_AL = 4'b0000;
    localparam logic [3:0] CC_EQ = 4'b0001;
    localparam logic [3:0] CC_NE = 4'b0010;
    localparam logic [3:0] CC_CS = 4'b0011;
    localparam logic [3:0] CC_CC = 4'b0100;
    localparam logic [3:0] CC_MI = 4'b0101;
    localparam logic [3:0] CC_PL = 4'b0110;
    localparam logic [3:0] CC_VS = 4'b0111;
    localparam logic [3:0] CC_VC = 4'b1000;
    localparam logic [3:0] CC_HI = 4'b1001;
    localparam logic [3:0] CC_LS = 4'b1010;
    localparam logic [3:0] CC_GE = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GT = 4'b1101;
    localparam logic [3:0] CC_LE = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    localparam logic [2:0] SH_NONE = 3'b000;
    localparam logic [2:0] SH_LSL  = 3'b001;
    localparam logic [2:0] SH_LSR  = 3'b010;
    localparam logic [2:0] SH_ASR  = 3'b011;
    localparam logic [2:0] SH_ROR  = 3'b100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_LOGIC,
        CLS_ARITH
    } alu_class_e;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, pass;
        n    = f[FLAG_N];
        z    = f[FLAG_Z];
        c    = f[FLAG_C];
        v    = f[FLAG_V];
        pass = 1'b0;
        case (cond)
            CC_AL:   pass = 1'b1;
            CC_EQ:   pass = z;
            CC_NE:   pass = !z;
            CC_CS:   pass = c;
            CC_CC:   pass = !c;
            CC_MI:   pass = n;
            CC_PL:   pass = !n;
            CC_VS:   pass = v;
            CC_VC:   pass = !v;
            CC_HI:   pass = c && !z;
            CC_LS:   pass = !c || z;
            CC_GE:   pass = (n == v);
            CC_LT:   pass = (n != v);
            CC_GT:   pass = !z && (n == v);
            CC_LE:   pass = z || (n != v);
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // Compare/test ops and the reserved encodings never write back.
    function automatic logic op_writes(input logic [3:0] op);
        return (op <= OP_MOV);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for operand B. carry_en=0 means "no shift took place",
// in which case the consumer substitutes the architectural C flag.
module alu_shifter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       sh_type,
    input  logic [SHW-1:0]   sh_amt,
    output logic [WIDTH-1:0] b_out,
    output logic             carry_out,
    output logic             carry_en
);

    // One extra bit on each shift captures the last bit shifted out.
    logic [WIDTH:0]     lsl_w;
    logic [WIDTH:0]     lsr_w;
    logic [WIDTH:0]     asr_w;
    logic [2*WIDTH-1:0] ror_w;

    assign lsl_w = {1'b0, b_in} << sh_amt;
    assign lsr_w = {b_in, 1'b0} >> sh_amt;
    assign asr_w = $signed({b_in, 1'b0}) >>> sh_amt;
    assign ror_w = {b_in, b_in} >> sh_amt;

    always_comb begin
        b_out     = b_in;
        carry_out = 1'b0;
        carry_en  = 1'b0;
        if (sh_amt != '0) begin
            case (sh_type)
                SH_LSL: begin
                    b_out     = lsl_w[WIDTH-1:0];
                    carry_out = lsl_w[WIDTH];
                    carry_en  = 1'b1;
                end
                SH_LSR: begin
                    b_out     = lsr_w[WIDTH:1];
                    carry_out = lsr_w[0];
                    carry_en  = 1'b1;
                end
                SH_ASR: begin
                    b_out     = asr_w[WIDTH:1];
                    carry_out = asr_w[0];
                    carry_en  = 1'b1;
                end
                SH_ROR: begin
                    b_out     = ror_w[WIDTH-1:0];
                    carry_out = ror_w[WIDTH-1];
                    carry_en  = 1'b1;
                end
                default: begin
                    b_out     = b_in;
                    carry_out = 1'b0;
                    carry_en  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with NZCV status register, conditional execution and
// valid/ready handshake on input and output.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int IMM_WIDTH = 16,
    localparam int SHW       = $clog2(WIDTH)
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [WIDTH-1:0]     In1,
    input  logic [WIDTH-1:0]     In2,
    input  logic [IMM_WIDTH-1:0] Immediate,
    input  logic                 Use_Imm,
    input  logic [3:0]           Opcode,
    input  logic [3:0]           Cond,
    input  logic [2:0]           SR_Cont,
    input  logic [SHW-1:0]       SR_Bit,
    input  logic                 S,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [WIDTH-1:0]     Out,
    output logic                 Out_Wr,
    output logic                 Out_Exec,
    output logic [3:0]           Flags
);

    // Stage-1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_sc_q, s1_sc_d;
    logic             s1_sc_en_q, s1_sc_en_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [3:0]       s1_cond_q, s1_cond_d;
    logic             s1_s_q, s1_s_d;

    // Stage-2 / output registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_wr_q, out_wr_d;
    logic             out_exec_q, out_exec_d;
    logic [3:0]       flags_q, flags_d;

    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] b_shifted;
    logic             sh_carry;
    logic             sh_carry_en;

    assign s2_adv   = !out_valid_q || Out_Ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign In_Ready = s1_adv;
    assign b_sel    = Use_Imm ? WIDTH'(Immediate) : In2;

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .b_in      (b_sel),
        .sh_type   (SR_Cont),
        .sh_amt    (SR_Bit),
        .b_out     (b_shifted),
        .carry_out (sh_carry),
        .carry_en  (sh_carry_en)
    );

    always_comb begin : s1_next
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sc_d    = s1_sc_q;
        s1_sc_en_d = s1_sc_en_q;
        s1_op_d    = s1_op_q;
        s1_cond_d  = s1_cond_q;
        s1_s_d     = s1_s_q;
        if (s1_adv) begin
            s1_valid_d = In_Valid;
            if (In_Valid) begin
                s1_a_d     = In1;
                s1_b_d     = b_shifted;
                s1_sc_d    = sh_carry;
                s1_sc_en_d = sh_carry_en;
                s1_op_d    = Opcode;
                s1_cond_d  = Cond;
                s1_s_d     = S;
            end
        end
    end

    // ALU core: operands are steered so one adder covers every add/subtract form.
    alu_class_e       cls;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] res;
    logic             arith_v;
    logic             shc;
    logic             pass;

    always_comb begin : alu_core
        opa       = s1_a_q;
        opb       = s1_b_q;
        cin       = 1'b0;
        logic_res = '0;
        cls       = CLS_NONE;
        // The carry for an unshifted operand is resolved here so it sees the latest C.
        shc       = s1_sc_en_q ? s1_sc_q : flags_q[FLAG_C];
        pass      = cond_pass(s1_cond_q, flags_q);
        case (s1_op_q)
            OP_AND, OP_TST: begin logic_res = s1_a_q & s1_b_q; cls = CLS_LOGIC; end
            OP_ORR:         begin logic_res = s1_a_q | s1_b_q; cls = CLS_LOGIC; end
            OP_EOR, OP_TEQ: begin logic_res = s1_a_q ^ s1_b_q; cls = CLS_LOGIC; end
            OP_MVN:         begin logic_res = ~s1_b_q;         cls = CLS_LOGIC; end
            OP_MOV:         begin logic_res = s1_b_q;          cls = CLS_LOGIC; end
            OP_ADD, OP_CMN: cls = CLS_ARITH;
            OP_ADC: begin
                cin = flags_q[FLAG_C];
                cls = CLS_ARITH;
            end
            OP_SUB, OP_CMP: begin
                opb = ~s1_b_q;
                cin = 1'b1;
                cls = CLS_ARITH;
            end
            OP_SBC: begin
                opb = ~s1_b_q;
                cin = flags_q[FLAG_C];
                cls = CLS_ARITH;
            end
            OP_RSB: begin
                opa = s1_b_q;
                opb = ~s1_a_q;
                cin = 1'b1;
                cls = CLS_ARITH;
            end
            default: cls = CLS_NONE;
        endcase
        sum     = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        arith_v = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
        case (cls)
            CLS_LOGIC: res = logic_res;
            CLS_ARITH: res = sum[WIDTH-1:0];
            default:   res = '0;
        endcase
    end

    always_comb begin : s2_next
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_wr_d    = out_wr_q;
        out_exec_d  = out_exec_q;
        flags_d     = flags_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_exec_d = pass;
                out_d      = pass ? res : '0;
                out_wr_d   = pass && op_writes(s1_op_q);
                if (pass && s1_s_q && (cls != CLS_NONE)) begin
                    flags_d[FLAG_N] = res[WIDTH-1];
                    flags_d[FLAG_Z] = (res == '0);
                    if (cls == CLS_ARITH) begin
                        flags_d[FLAG_C] = sum[WIDTH];
                        flags_d[FLAG_V] = arith_v;
                    end else begin
                        flags_d[FLAG_C] = shc;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sc_q     <= 1'b0;
            s1_sc_en_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_cond_q   <= '0;
            s1_s_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_wr_q    <= 1'b0;
            out_exec_q  <= 1'b0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_sc_q     <= s1_sc_d;
            s1_sc_en_q  <= s1_sc_en_d;
            s1_op_q     <= s1_op_d;
            s1_cond_q   <= s1_cond_d;
            s1_s_q      <= s1_s_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_wr_q    <= out_wr_d;
            out_exec_q  <= out_exec_d;
            flags_q     <= flags_d;
        end
    end

    assign Out_Valid = out_valid_q;
    assign Out       = out_q;
    assign Out_Wr    = out_wr_q;
    assign Out_Exec  = out_exec_q;
    assign Flags     = flags_q;

endmodule
